// File: rtl/sound_pkg.sv
// Types and volume bounds shared by the sound channel blocks.
package sound_pkg;

    typedef logic [2:0] period_t;
    typedef logic [3:0] volume_t;

    localparam volume_t VOL_MIN = 4'h0;
    localparam volume_t VOL_MAX = 4'hF;

endpackage : sound_pkg

// File: rtl/volumizer_envelope_timer.sv
// Reloadable 3-bit down-counter that strobes `tick` once every `load_value`
// enabled cycles. A load restarts the count and never produces a tick.
module envelope_timer
    import sound_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] load_value,
    input  logic       enable,
    output logic       tick
);

    period_t timer_q;
    period_t timer_d;

    // Next count: load wins, otherwise count down and reload on expiry.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        timer_d = timer_q;
        tick    = 1'b0;
        if (load) begin
            timer_d = load_value;
        end else if (enable) begin
            if (timer_q > 3'd1) begin
                timer_d = timer_q - 3'd1;
            end else begin
                timer_d = load_value;
                tick    = 1'b1;
            end
        end
    end

    // Counter register, cleared so the timer is idle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule : envelope_timer

// File: rtl/volumizer.sv
// Volume-envelope generator: loads a start volume on trigger, then steps it
// up or down by one every `per` envelope ticks, saturating at 0 and 15.
module volumizer
    import sound_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       envelope_add,
    input  logic       trigger,
    input  logic [2:0] period,
    input  logic [3:0] starting_volume,
    output logic [3:0] volume
);

    volume_t volume_q;
    volume_t volume_d;
    logic    dir_q;
    logic    dir_d;
    period_t per_q;
    period_t per_d;

    logic    step_tick;
    period_t timer_reload;
    logic    timer_enable;

    // On trigger the timer restarts from the new period; otherwise it
    // reloads from the latched period. A zero period freezes the envelope.
    assign timer_reload = trigger ? period : per_q;
    assign timer_enable = (per_q != 3'd0);

    envelope_timer u_envelope_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (trigger),
        .load_value (timer_reload),
        .enable     (timer_enable),
        .tick       (step_tick)
    );

    // Latch settings on trigger; on a timer tick step volume with saturation.
    always_comb begin
        volume_d = volume_q;
        dir_d    = dir_q;
        per_d    = per_q;
        if (trigger) begin
            volume_d = starting_volume;
            dir_d    = envelope_add;
            per_d    = period;
        end else if (step_tick) begin
            // Bound check first, so the 4-bit value never wraps.
            if (dir_q && (volume_q != VOL_MAX)) begin
                volume_d = volume_q + 4'd1;
            end else if (!dir_q && (volume_q != VOL_MIN)) begin
                volume_d = volume_q - 4'd1;
            end
        end
    end

    // Envelope state; reset leaves the block silent and disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            volume_q <= VOL_MIN;
            dir_q    <= 1'b0;
            per_q    <= '0;
        end else begin
            volume_q <= volume_d;
            dir_q    <= dir_d;
            per_q    <= per_d;
        end
    end

    assign volume = volume_q;

endmodule : volumizer

// File: tb/tb_volumizer.sv
// Self-checking bench for volumizer: directed scenarios plus random triggers,
// compared against a closed-form envelope model (volume as a function of the
// edges elapsed since the last trigger).
module tb_volumizer;

    logic       clk;
    logic       rst_n;
    logic       envelope_add;
    logic       trigger;
    logic [2:0] period;
    logic [3:0] starting_volume;
    logic [3:0] volume;

    int n_checks;
    int n_pass;

    // Reference model state.
    bit m_active;
    int m_start;
    bit m_up;
    int m_per;
    int m_edges;

    volumizer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .envelope_add    (envelope_add),
        .trigger         (trigger),
        .period          (period),
        .starting_volume (starting_volume),
        .volume          (volume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected volume: start +/- (elapsed edges / period), clamped to 0..15.
    function automatic logic [3:0] model_volume();
        int steps;
        int v;
        if (!m_active) return 4'd0;
        if (m_per == 0) return 4'(m_start);
        steps = m_edges / m_per;
        v = m_up ? m_start + steps : m_start - steps;
        if (v > 15) v = 15;
        if (v < 0) v = 0;
        return 4'(v);
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: volume=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one edge's inputs at the falling edge, update the model at the
    // rising edge, and compare shortly afterwards.
    task automatic edge_step(input string tag, input logic trig, input logic add,
                             input logic [2:0] per, input logic [3:0] sv);
        @(negedge clk);
        trigger         = trig;
        envelope_add    = add;
        period          = per;
        starting_volume = sv;
        @(posedge clk);
        if (trig) begin
            m_active = 1'b1;
            m_start  = int'(sv);
            m_up     = add;
            m_per    = int'(per);
            m_edges  = 0;
        end else begin
            m_edges++;
        end
        #1;
        check(tag, volume, model_volume());
    endtask

    // Non-trigger edges with scrambled settings, which must be ignored.
    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            edge_step(tag, 1'b0, 1'($urandom_range(1)), 3'($urandom_range(7)),
                      4'($urandom_range(15)));
        end
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        m_active        = 1'b0;
        m_start         = 0;
        m_up            = 1'b0;
        m_per           = 0;
        m_edges         = 0;
        rst_n           = 1'b0;
        trigger         = 1'b0;
        envelope_add    = 1'b0;
        period          = 3'd0;
        starting_volume = 4'd0;

        #1;
        check("reset_value", volume, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("no_trigger", 10);

        // Descent from 15 at one step per edge, then hold at 0.
        edge_step("down_load", 1'b1, 1'b0, 3'd1, 4'd15);
        check("down_load_const", volume, 4'd15);
        idle("down_run", 14);
        edge_step("down_reach0", 1'b0, 1'b0, 3'd1, 4'd0);
        check("down_reach0_const", volume, 4'd0);
        idle("down_hold0", 12);

        // Ascent from 8, reaching 15 on the 7th edge, no wrap.
        edge_step("up_load", 1'b1, 1'b1, 3'd1, 4'd8);
        idle("up_run", 6);
        edge_step("up_reach15", 1'b0, 1'b1, 3'd1, 4'd0);
        check("up_reach15_const", volume, 4'd15);
        idle("up_hold15", 12);

        // Period 3 cadence; period input changed to 1 without trigger.
        edge_step("p3_load", 1'b1, 1'b0, 3'd3, 4'd10);
        for (int i = 0; i < 9; i++) edge_step("p3_run", 1'b0, 1'b1, 3'd1, 4'd15);
        check("p3_after9", volume, 4'd7);

        // Disabled envelope, then a fresh trigger.
        edge_step("p0_load", 1'b1, 1'b0, 3'd0, 4'd6);
        idle("p0_hold", 20);
        check("p0_hold_const", volume, 4'd6);
        edge_step("p0_retrig", 1'b1, 1'b0, 3'd0, 4'd2);
        check("p0_retrig_const", volume, 4'd2);

        // Retrigger mid-descent at volume 9 with an ascent from 12.
        edge_step("mid_load", 1'b1, 1'b0, 3'd1, 4'd15);
        idle("mid_run", 6);
        check("mid_at9", volume, 4'd9);
        edge_step("mid_retrig", 1'b1, 1'b1, 3'd1, 4'd12);
        idle("mid_up", 5);

        // Trigger held for several edges: phase restarts from the last one.
        for (int i = 0; i < 4; i++) edge_step("held_trig", 1'b1, 1'b0, 3'd2, 4'd5);
        idle("held_after", 8);

        // Asynchronous reset between edges.
        edge_step("rst_load", 1'b1, 1'b1, 3'd2, 4'd4);
        idle("rst_run", 3);
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        m_active = 1'b0;
        #1;
        check("async_reset", volume, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_reset", 6);

        // Random triggers and settings against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) begin
                edge_step("rand_trig", 1'b1, 1'($urandom_range(1)),
                          3'($urandom_range(7)), 4'($urandom_range(15)));
            end else begin
                idle("rand_idle", 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_volumizer

// File: doc/volumizer.md
# volumizer

Volume-envelope generator for one Game Boy–style sound channel. On a trigger it loads a 4-bit starting volume. It then steps the volume up or down by one every `period` envelope ticks, saturating at 0 or 15. It sits between the channel register file and the channel DAC/mixer. `clk` is the envelope tick, nominally 64 Hz from the frame sequencer, so one clock equals one envelope tick.

## Interface
- No parameters.
- `clk`  input  1  envelope tick clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `envelope_add`  input  1  direction: 1 = increase, 0 = decrease. Sampled only on trigger.
- `trigger`  input  1  synchronous, level-sampled restart. Every edge with `trigger`=1 reloads the envelope.
- `period`  input  3  envelope step period in ticks. 0 = envelope disabled. Sampled only on trigger.
- `starting_volume`  input  4  initial volume. Sampled only on trigger.
- `volume`  output  4  current envelope volume, registered.

## Operation
- Internal state:
  - `volume` register (4 bits).
  - latched direction `dir` (1 bit).
  - latched period `per` (3 bits).
  - down-counter `timer` (3 bits).
- Trigger edge (`trigger`=1):
  - `volume` ← `starting_volume`.
  - `dir` ← `envelope_add`.
  - `per` ← `period`.
  - `timer` ← `period`.
  - No volume step occurs on this edge.
- Non-trigger edge with `per`=0: all state holds; the envelope is disabled.
- Non-trigger edge with `per`≠0:
  - If `timer` > 1: `timer` ← `timer`−1, and volume holds.
  - If `timer` ≤ 1: `timer` ← `per`, and volume steps once.
- Step rules:
  - `dir`=1 and `volume` < 15: `volume` ← `volume`+1.
  - `dir`=0 and `volume` > 0: `volume` ← `volume`−1.
  - Otherwise `volume` holds (saturation, no wrap). The timer keeps reloading but has no further effect.
- Changes to `envelope_add`, `period` or `starting_volume` between triggers have no effect until the next trigger.
- Arithmetic is 4-bit unsigned. The bound check precedes the increment/decrement, so neither 15→0 nor 0→15 is ever produced.

## Timing
- Reset (asynchronous assert, release synchronous to `clk`) sets:
  - `volume`=0, `dir`=0, `per`=0, `timer`=0.
  - The block is therefore idle (disabled) until the first trigger.
- Trigger sampled at edge T: `volume` = `starting_volume` immediately after T.
- First step is at edge T+`per`, then every `per` edges.
- From start volume S, decreasing, the volume reaches 0 at edge T+S·`per`. Increasing, it reaches 15 at T+(15−S)·`per`.
- `trigger` held for k edges: the volume is reloaded on each of those edges. Counting of `per` restarts from the last edge with `trigger`=1.
- Trigger mid-envelope, including during saturation: this is a full restart, and the old timer phase is discarded.
- Reset mid-envelope: `volume` goes to 0 without waiting for a clock edge, and the block stays disabled until the next trigger.

## Structure
- Shared package `sound_pkg` holds `VOL_MIN`=4'h0, `VOL_MAX`=4'hF, and the `period_t` (3-bit) and `volume_t` (4-bit) typedefs. These are shared with the other channel blocks.
- One natural sub-module, `envelope_timer`:
  - Contains the 3-bit reloadable down-counter.
  - Inputs: `clk`, `rst_n`, `load`, `load_value`, `enable`.
  - Output: `tick` (a 1-cycle step strobe).
  - The top module holds the volume register, the latched `dir`, and the saturation logic.

## Test plan
- Reset, no trigger, 10 clocks → `volume` stays 0.
- `starting_volume`=15, `period`=1, `envelope_add`=0, one-cycle trigger → `volume`=15 after the trigger edge. It then reads 14, 13, …, 0 on successive edges (0 at the 15th edge after the trigger) and holds 0 for 10+ further edges.
- `starting_volume`=8, `period`=1, `envelope_add`=1, one-cycle trigger → 8, 9, …, 15 (15 at the 7th edge after the trigger) and holds 15 with no wrap to 0.
- `starting_volume`=10, `period`=3, down → the volume changes only every 3rd edge: 10, 10, 10, 9, 9, 9, 8, …. Changing `period` to 1 without a trigger does not alter this cadence.
- `period`=0, `starting_volume`=6, trigger → `volume`=6 for 20 edges. A subsequent trigger with `starting_volume`=2 → `volume`=2 on the next edge.
- Mid-envelope checks:
  - Trigger during a descent from 15 (at volume 9) with start 12, up → 12, 13, 14, 15.
  - Deassert `rst_n` between clock edges → `volume`=0 asynchronously, and it remains 0 after release until the next trigger.
